// File: rtl/commit_trace_fifo_pkg.sv
// rtl/commit_trace_fifo_pkg.sv - shared widths, entry layout and packing helper for the commit trace FIFO
package commit_trace_fifo_pkg;

    localparam int TRACE_SEQ_W   = 16;
    localparam int TRACE_DATA_W  = 32;
    localparam int TRACE_ENTRY_W = TRACE_SEQ_W + 3 * TRACE_DATA_W;

    // Entry layout, LSB first: result, inst, pc, seq
    localparam int RESULT_LSB = 0;
    localparam int INST_LSB   = RESULT_LSB + TRACE_DATA_W;
    localparam int PC_LSB     = INST_LSB + TRACE_DATA_W;
    localparam int SEQ_LSB    = PC_LSB + TRACE_DATA_W;

    typedef logic [TRACE_SEQ_W-1:0]   seq_t;
    typedef logic [TRACE_DATA_W-1:0]  word_t;
    typedef logic [TRACE_ENTRY_W-1:0] entry_t;

    function automatic entry_t pack_entry(input seq_t seq, input word_t pc,
                                          input word_t inst, input word_t result);
        entry_t e;
        e = '0;
        e[SEQ_LSB    +: TRACE_SEQ_W]  = seq;
        e[PC_LSB     +: TRACE_DATA_W] = pc;
        e[INST_LSB   +: TRACE_DATA_W] = inst;
        e[RESULT_LSB +: TRACE_DATA_W] = result;
        return e;
    endfunction

endpackage

// File: rtl/commit_trace_fifo_if.sv
// rtl/commit_trace_fifo_if.sv - write-back commit input and trace output handshake bundle
interface commit_trace_fifo_if;
    import commit_trace_fifo_pkg::*;

    logic  wb_valid;
    word_t wb_pc;
    word_t wb_inst;
    word_t wb_result;

    logic  out_valid;
    logic  out_ready;
    seq_t  out_seq;
    word_t out_pc;
    word_t out_inst;
    word_t out_result;

    modport master (
        output wb_valid, wb_pc, wb_inst, wb_result, out_ready,
        input  out_valid, out_seq, out_pc, out_inst, out_result
    );

    modport slave (
        input  wb_valid, wb_pc, wb_inst, wb_result, out_ready,
        output out_valid, out_seq, out_pc, out_inst, out_result
    );

endinterface

// File: rtl/commit_trace_fifo_mem.sv
// rtl/commit_trace_fifo_mem.sv - DEPTH x entry register array, synchronous write, asynchronous read
module commit_trace_fifo_mem
    import commit_trace_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  entry_t        wdata_i,
    input  logic [AW-1:0] raddr_i,
    output entry_t        rdata_o
);

    entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - captures retired instructions into a sequence-tagged FIFO;
// overflow drops and counts entries rather than stalling the pipeline.
module commit_trace_fifo
    import commit_trace_fifo_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int DROP_NOP = 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    commit_trace_fifo_if.slave     bus_if,
    output logic [CW-1:0]          count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [TRACE_SEQ_W-1:0] drop_cnt_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    seq_t          seq_q, seq_d;
    seq_t          drop_q, drop_d;

    logic   full, empty;
    logic   cap, pop, push, drop;
    entry_t wr_entry;
    entry_t rd_entry;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A zero instruction word is a pipeline bubble; optionally it never enters the trace
    assign cap  = bus_if.wb_valid && !((DROP_NOP != 0) && (bus_if.wb_inst == '0));
    assign pop  = !empty && bus_if.out_ready;
    assign push = cap && (!full || pop);
    assign drop = cap && full && !pop;

    assign wr_entry = pack_entry(seq_q, bus_if.wb_pc, bus_if.wb_inst, bus_if.wb_result);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        seq_d    = seq_q;
        drop_d   = drop_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // Sequence advances for dropped commits too, so gaps in out_seq expose drops
        if (cap) begin
            seq_d = seq_q + 16'd1;
        end
        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
        end
    end

    // Writes are gated off during reset so the reset cycle never lands data in storage
    commit_trace_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push && !reset_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign bus_if.out_valid  = !empty;
    assign bus_if.out_seq    = rd_entry[SEQ_LSB    +: TRACE_SEQ_W];
    assign bus_if.out_pc     = rd_entry[PC_LSB     +: TRACE_DATA_W];
    assign bus_if.out_inst   = rd_entry[INST_LSB   +: TRACE_DATA_W];
    assign bus_if.out_result = rd_entry[RESULT_LSB +: TRACE_DATA_W];

    assign count_o    = count_q;
    assign full_o     = full;
    assign empty_o    = empty;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb/tb_commit_trace_fifo.sv - directed table and sequence checks for commit_trace_fifo
module tb_commit_trace_fifo;

    logic        clk;
    logic        reset;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    commit_trace_fifo_if bus ();

    commit_trace_fifo #(
        .DEPTH    (16),
        .DROP_NOP (1)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .bus_if     (bus),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty),
        .drop_cnt_o (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] res;
        logic        rdy;
        logic        e_ov;
        logic [15:0] e_seq;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_res;
        logic [4:0]  e_cnt;
        logic        e_full;
        logic        e_empty;
        logic [15:0] e_drop;
    } vec_t;

    typedef struct {
        logic [15:0] seq;
        logic [31:0] pc;
    } ent_t;

    vec_t vecs [11];
    ent_t mq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] pc,
                        input logic [31:0] inst, input logic [31:0] res, input logic rdy);
        reset         = r;
        bus.wb_valid  = v;
        bus.wb_pc     = pc;
        bus.wb_inst   = inst;
        bus.wb_result = res;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_pc     = '0;
        bus.wb_inst   = '0;
        bus.wb_result = '0;
        bus.out_ready = 1'b0;

        // Basic flow with out_ready high, then DROP_NOP filtering
        vecs[0]  = '{1'b1, 1'b0, 32'h0,   32'h0,        32'h0, 1'b0,
                     1'b0, 16'd0, 32'h0,   32'h0,        32'h0, 5'd0, 1'b0, 1'b1, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0,   32'h13,       32'h1, 1'b1,
                     1'b1, 16'd0, 32'h0,   32'h13,       32'h1, 5'd1, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 32'h4,   32'h13,       32'h2, 1'b1,
                     1'b1, 16'd1, 32'h4,   32'h13,       32'h2, 5'd1, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 32'h8,   32'h13,       32'h3, 1'b1,
                     1'b1, 16'd2, 32'h8,   32'h13,       32'h3, 5'd1, 1'b0, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h0, 1'b1,
                     1'b0, 16'd0, 32'h0,   32'h0,        32'h0, 5'd0, 1'b0, 1'b1, 16'd0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,   32'h0,        32'h0, 1'b0,
                     1'b0, 16'd0, 32'h0,   32'h0,        32'h0, 5'd0, 1'b0, 1'b1, 16'd0};
        vecs[6]  = '{1'b0, 1'b1, 32'h100, 32'h20080005, 32'h5, 1'b0,
                     1'b1, 16'd0, 32'h100, 32'h20080005, 32'h5, 5'd1, 1'b0, 1'b0, 16'd0};
        vecs[7]  = '{1'b0, 1'b1, 32'h104, 32'h0,        32'h0, 1'b0,
                     1'b1, 16'd0, 32'h100, 32'h20080005, 32'h5, 5'd1, 1'b0, 1'b0, 16'd0};
        vecs[8]  = '{1'b0, 1'b1, 32'h108, 32'h20090003, 32'h3, 1'b0,
                     1'b1, 16'd0, 32'h100, 32'h20080005, 32'h5, 5'd2, 1'b0, 1'b0, 16'd0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h0, 1'b1,
                     1'b1, 16'd1, 32'h108, 32'h20090003, 32'h3, 5'd1, 1'b0, 1'b0, 16'd0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h0, 1'b1,
                     1'b0, 16'd0, 32'h0,   32'h0,        32'h0, 5'd0, 1'b0, 1'b1, 16'd0};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].pc, vecs[i].inst, vecs[i].res, vecs[i].rdy);
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].e_drop));
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d_seq", i), 32'(bus.out_seq), 32'(vecs[i].e_seq));
                chk($sformatf("vec%0d_pc", i), bus.out_pc, vecs[i].e_pc);
                chk($sformatf("vec%0d_inst", i), bus.out_inst, vecs[i].e_inst);
                chk($sformatf("vec%0d_res", i), bus.out_result, vecs[i].e_res);
            end
        end

        // Overflow: 18 commits into 16 slots, then drain
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            step(1'b0, 1'b1, 32'(i * 4), 32'h100 + 32'(i), 32'(i), 1'b0);
        end
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_seq", i), 32'(bus.out_seq), 32'(i));
            chk($sformatf("drain%0d_pc", i), bus.out_pc, 32'(i * 4));
            step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 32'h500, 32'h33, 32'h55, 1'b0);
        chk("post_ovf_seq", 32'(bus.out_seq), 32'd18);
        chk("post_ovf_pc", bus.out_pc, 32'h500);

        // Reset with 5 entries buffered and a nonzero drop count
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 32'h600 + 32'(i * 4), 32'h13, 32'(i), 1'b0);
        end
        chk("pre_rst_count", 32'(count), 32'd5);
        chk("pre_rst_drop", 32'(drop_cnt), 32'd2);
        step(1'b1, 1'b1, 32'hDEAD0000, 32'h13, 32'h0, 1'b1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, 1'b1, 32'h700, 32'h13, 32'h77, 1'b0);
        chk("rst_next_valid", 32'(bus.out_valid), 32'd1);
        chk("rst_next_seq", 32'(bus.out_seq), 32'd0);
        chk("rst_next_pc", bus.out_pc, 32'h700);

        // Full, then capture and pop in the same cycle
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 32'(i * 4), 32'h13, 32'(i), 1'b0);
        end
        chk("fill_count", 32'(count), 32'd16);
        step(1'b0, 1'b1, 32'h900, 32'h77, 32'hAB, 1'b1);
        chk("cappop_count", 32'(count), 32'd16);
        chk("cappop_full", 32'(full), 32'd1);
        chk("cappop_drop", 32'(drop_cnt), 32'd0);
        chk("cappop_head", 32'(bus.out_seq), 32'd1);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("cappop_drain%0d", i), 32'(bus.out_seq), 32'(i + 1));
            step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        end
        chk("cappop_tail_seq", 32'(bus.out_seq), 32'd16);
        chk("cappop_tail_pc", bus.out_pc, 32'h900);
        chk("cappop_tail_res", bus.out_result, 32'hAB);
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        chk("cappop_final_empty", 32'(empty), 32'd1);

        // out_ready toggling during continuous commits, checked against a model queue
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        mq.delete();
        for (int c = 0; c < 12; c++) begin
            logic rdy;
            ent_t e;
            rdy = c[0];
            if (bus.out_valid) begin
                if (mq.size() == 0) begin
                    chk($sformatf("tog%0d_model_nonempty", c), 32'd0, 32'd1);
                end else begin
                    chk($sformatf("tog%0d_seq", c), 32'(bus.out_seq), 32'(mq[0].seq));
                    chk($sformatf("tog%0d_pc", c), bus.out_pc, mq[0].pc);
                    if (rdy) begin
                        void'(mq.pop_front());
                    end
                end
            end
            e.seq = 16'(c);
            e.pc  = 32'hA000 + 32'(c * 4);
            mq.push_back(e);
            step(1'b0, 1'b1, e.pc, 32'h13, 32'(c), rdy);
        end
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid && mq.size() != 0) begin
                chk($sformatf("togdrain%0d_seq", c), 32'(bus.out_seq), 32'(mq[0].seq));
                void'(mq.pop_front());
            end
            step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        end
        chk("tog_model_left", 32'(mq.size()), 32'd0);
        chk("tog_empty", 32'(empty), 32'd1);
        chk("tog_drop", 32'(drop_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/commit_trace_fifo.md
# commit_trace_fifo

Captures every instruction retired by the pipelined CPU's write-back stage (PC, instruction word, result) into a small FIFO, tags each with a sequence number, and presents it to a host-side consumer through a valid/ready handshake. It sits directly downstream of the CPU's WB outputs and decouples the one-commit-per-cycle pipeline from a slower trace reader (UART dumper, bench checker). Overflow never stalls the CPU: entries are dropped and counted instead.

## Interface
- DEPTH, 16 — entries; power of two, 4..256
- DROP_NOP, 1 — when 1, commits with inst == 32'h0000_0000 are not captured and do not consume a sequence number

- clk  in  1  — single clock, rising edge
- reset  in  1  — synchronous, active-high
- wb_valid  in  1  — one instruction retires this cycle
- wb_pc  in  32  — PC of retiring instruction
- wb_inst  in  32  — instruction word
- wb_result  in  32  — write-back value
- out_valid  out  1  — head entry available
- out_ready  in  1  — consumer accepts head this cycle
- out_seq  out  16  — sequence tag of head
- out_pc / out_inst / out_result  out  32 each  — head fields
- count  out  log2(DEPTH)+1  — occupancy
- full / empty  out  1 each
- drop_cnt  out  16  — dropped commits, saturating

## Operation
- Capture condition: cap = wb_valid && !(DROP_NOP && wb_inst == 0).
- Sequence counter seq (16 bit) increments on every cap, whether stored or dropped; wraps 16'hFFFF -> 0. Stored entry carries the pre-increment value. Gaps in out_seq therefore mark drops.
- Pop condition: pop = out_valid && out_ready.
- Push condition: push = cap && (!full || pop). Full with simultaneous pop: push and pop both occur, count unchanged.
- Drop condition: cap && full && !pop -> entry discarded, drop_cnt increments, saturates at 16'hFFFF.
- Empty with cap: entry written; not visible at output until next cycle (no bypass).
- Pointers: rd_ptr/wr_ptr log2(DEPTH) bits, wrap naturally; count tracked separately; full = (count == DEPTH), empty = (count == 0).
- Output is first-word-fall-through: out_valid = !empty; out_* driven combinationally from storage at rd_ptr; out_* are don't-care when out_valid = 0 but must hold stable while out_valid && !out_ready.
- Consumer may hold out_ready high permanently; throughput one entry per cycle.

## Timing
- Reset (synchronous, sampled at rising edge): rd_ptr, wr_ptr, count, seq, drop_cnt -> 0; empty = 1, full = 0, out_valid = 0. Storage contents not cleared. Inputs in the reset cycle are ignored (no capture, no pop, no seq increment).
- Reset asserted mid-operation: all buffered entries discarded, next captured commit gets seq 0.
- Latency: cap in cycle N -> out_valid / data visible in cycle N+1 (if FIFO was empty).
- count, full, empty, drop_cnt all registered-state derived; update one cycle after the triggering edge's inputs.
- No combinational path from wb_* to out_*; out_valid depends only on state; out_ready affects only next state.

## Structure
- Shared header/package trace_defs: TRACE_SEQ_W = 16, TRACE_DATA_W = 32, entry layout constant (seq, pc, inst, result = 112 bits) and field offsets.
- One sub-module: trace_fifo_mem — DEPTH x 112 register array, synchronous write port, asynchronous read port; no reset.
- Top holds pointers, counters, handshake logic.

## Test plan
- Reset then 3 commits (pc 0x00,0x04,0x08; result 1,2,3), out_ready = 1 -> three outputs, out_seq 0,1,2, correct fields, each one cycle after capture; count returns to 0.
- DROP_NOP = 1, commits inst 0x20080005, 0x00000000, 0x20090003 -> two entries, out_seq 0,1; drop_cnt stays 0.
- out_ready = 0, 18 commits with DEPTH = 16 -> full = 1, count = 16, drop_cnt = 2; then drain: out_seq 0..15, seq of next capture is 18.
- Full, then cap and pop same cycle -> count stays 16, drop_cnt unchanged, new entry appears at tail with next seq.
- out_ready toggled 1/0 every cycle during continuous commits -> out_* stable whenever out_valid && !out_ready; no entry lost until full.
- Reset asserted with 5 entries buffered -> next cycle empty = 1, count = 0, drop_cnt = 0; next commit emerges with out_seq 0.
